// File: rtl/text_row_fetcher_if.sv
// Handshake bundle between the row fetcher, its SDRAM read port and the video side.
interface text_row_fetcher_if;
    logic        fetch_start;
    logic [5:0]  fetch_row;
    logic        busy;
    logic        fetch_done;
    logic        swap;
    logic [22:0] rd_address;
    logic        rd_request;
    logic [31:0] rd_data;
    logic        rd_done;
    logic [6:0]  cell_column;
    logic [31:0] cell_out;

    modport master (
        output fetch_start, fetch_row, swap, rd_data, rd_done, cell_column,
        input  busy, fetch_done, rd_address, rd_request, cell_out
    );

    modport slave (
        input  fetch_start, fetch_row, swap, rd_data, rd_done, cell_column,
        output busy, fetch_done, rd_address, rd_request, cell_out
    );
endinterface

// File: rtl/text_row_fetcher.sv
// Fetches one character row of cells from SDRAM into the back half of a
// double-buffered line buffer while the video side reads the front half.
module text_row_fetcher #(
    parameter int          COLUMNS    = 80,
    parameter int          ROWS       = 51,
    parameter logic [31:0] BLANK_CELL = 32'h0F040020
) (
    input  logic              clk,
    input  logic              reset,
    text_row_fetcher_if.slave bus
);
    localparam int          MEM_DEPTH = 2 * COLUMNS;
    localparam int          MEM_AW    = $clog2(MEM_DEPTH);
    localparam logic [6:0]  LAST_COL  = 7'(COLUMNS - 1);
    localparam logic [6:0]  NUM_COLS  = 7'(COLUMNS);
    localparam logic [6:0]  NUM_ROWS  = 7'(ROWS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_BLANK,
        ST_FINISH
    } state_t;

    state_t      state_reg;
    logic [5:0]  row_reg;
    logic [6:0]  col_reg;
    logic        busy_reg;
    logic        fetch_done_reg;
    logic        rd_request_reg;
    logic [22:0] rd_address_reg;
    logic        front_reg;
    logic        swap_pending_reg;
    logic [31:0] cell_out_reg;

    logic [31:0]       line_mem [0:MEM_DEPTH-1];
    logic              wr_en;
    logic [31:0]       wr_data;
    logic [MEM_AW-1:0] wr_index;
    logic [MEM_AW-1:0] rd_index;
    logic              last_col;
    logic              finish_now;

    function automatic logic [22:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
        logic [22:0] idx;
        idx = 23'(row) * 23'(COLUMNS) + 23'(col);
        return {idx[20:0], 2'b00};
    endfunction

    // Bank 0 occupies words [0, COLUMNS), bank 1 occupies [COLUMNS, 2*COLUMNS).
    function automatic logic [MEM_AW-1:0] bank_index(input logic bank, input logic [6:0] col);
        return bank ? MEM_AW'(COLUMNS) + MEM_AW'(col) : MEM_AW'(col);
    endfunction

    assign last_col   = (col_reg == LAST_COL);
    assign finish_now = last_col && ((state_reg == ST_WAIT && bus.rd_done) || state_reg == ST_BLANK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            row_reg          <= '0;
            col_reg          <= '0;
            busy_reg         <= 1'b0;
            fetch_done_reg   <= 1'b0;
            rd_request_reg   <= 1'b0;
            rd_address_reg   <= '0;
            front_reg        <= 1'b0;
            swap_pending_reg <= 1'b0;
        end else begin
            fetch_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.fetch_start) begin
                        row_reg  <= bus.fetch_row;
                        col_reg  <= '0;
                        busy_reg <= 1'b1;
                        if ({1'b0, bus.fetch_row} < NUM_ROWS) begin
                            state_reg      <= ST_ISSUE;
                            rd_request_reg <= 1'b1;
                            rd_address_reg <= cell_addr(bus.fetch_row, 7'd0);
                        end else begin
                            state_reg <= ST_BLANK;
                        end
                    end
                end
                ST_ISSUE: begin
                    rd_request_reg <= 1'b0;
                    state_reg      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.rd_done && !last_col) begin
                        col_reg        <= col_reg + 7'd1;
                        state_reg      <= ST_ISSUE;
                        rd_request_reg <= 1'b1;
                        rd_address_reg <= cell_addr(row_reg, col_reg + 7'd1);
                    end
                end
                ST_BLANK: begin
                    if (!last_col) begin
                        col_reg <= col_reg + 7'd1;
                    end
                end
                ST_FINISH: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase

            if (finish_now) begin
                state_reg      <= ST_FINISH;
                busy_reg       <= 1'b0;
                fetch_done_reg <= 1'b1;
            end

            // A swap requested during a fetch is deferred so the new row never shows half-filled.
            if (finish_now) begin
                front_reg        <= front_reg ^ (swap_pending_reg | bus.swap);
                swap_pending_reg <= 1'b0;
            end else if (bus.swap) begin
                if (busy_reg) begin
                    swap_pending_reg <= 1'b1;
                end else begin
                    front_reg <= ~front_reg;
                end
            end
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_data = BLANK_CELL;
        if (!reset && state_reg == ST_WAIT && bus.rd_done) begin
            wr_en   = 1'b1;
            wr_data = bus.rd_data;
        end else if (!reset && state_reg == ST_BLANK) begin
            wr_en = 1'b1;
        end
    end

    assign wr_index = bank_index(~front_reg, col_reg);
    assign rd_index = bank_index(front_reg, bus.cell_column);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_mem[wr_index] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cell_out_reg <= '0;
        end else if (bus.cell_column < NUM_COLS) begin
            cell_out_reg <= line_mem[rd_index];
        end else begin
            cell_out_reg <= BLANK_CELL;
        end
    end

    assign bus.busy       = busy_reg;
    assign bus.fetch_done = fetch_done_reg;
    assign bus.rd_request = rd_request_reg;
    assign bus.rd_address = rd_address_reg;
    assign bus.cell_out   = cell_out_reg;
endmodule

// File: tb/tb_text_row_fetcher.sv
// Bench for text_row_fetcher: table of fetch scenarios, randomized fetches against
// a row-level model of both banks, and a reset-during-fetch sequence.
module tb_text_row_fetcher;
    localparam int          COLUMNS    = 80;
    localparam int          ROWS       = 51;
    localparam logic [31:0] BLANK_CELL = 32'h0F040020;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    text_row_fetcher_if bus ();

    text_row_fetcher #(
        .COLUMNS   (COLUMNS),
        .ROWS      (ROWS),
        .BLANK_CELL(BLANK_CELL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int row;
        int max_lat;
        bit swap_mid;
        bit refetch;
        int exp_first;
        int exp_last;
        int exp_reqs;
        int exp_cycles;
    } vec_t;

    vec_t        vecs [5];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_bank [2][COLUMNS];
    bit          bank_known [2];
    int          model_front;

    // Expected cell of a row: the memory returns its own byte address, rows past the screen are blank.
    function automatic logic [31:0] ref_cell(input int row, input int col);
        if (row >= ROWS) return BLANK_CELL;
        return 32'(4 * (row * COLUMNS + col));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.swap        = 1'b0;
        bus.fetch_start = 1'b0;
        bus.rd_done     = 1'b0;
    endtask

    task automatic do_swap();
        bus.swap = 1'b1;
        tick();
        model_front = 1 - model_front;
    endtask

    task automatic verify_front(input string tag);
        int errs_before;
        errs_before = failures;
        for (int c = 0; c < COLUMNS + 2; c++) begin
            bus.cell_column = 7'(c);
            tick();
            check("front_col", bus.cell_out, (c < COLUMNS) ? model_bank[model_front][c] : BLANK_CELL);
        end
        bus.cell_column = 7'd127;
        tick();
        check("front_col_max", bus.cell_out, BLANK_CELL);
        $display("verify %s front=%0d new_errors=%0d", tag, model_front, failures - errs_before);
    endtask

    task automatic run_fetch(input int row, input int max_lat, input bit swap_mid, input bit refetch,
                             input bit swap_first, input int abort_at,
                             output int n_req, output int first_addr, output int last_addr,
                             output int total_cycles);
        int          vcol, back, cycles, lat_left;
        logic [31:0] hold_val;
        logic [22:0] req_addr;
        bit          hold_known, pending, done, aborted;
        vcol = int'($urandom_range(0, COLUMNS - 1));
        bus.cell_column = 7'(vcol);
        tick();
        if (swap_first) model_front = 1 - model_front;
        back       = 1 - model_front;
        hold_val   = model_bank[model_front][vcol];
        hold_known = bank_known[model_front];
        n_req = 0; first_addr = -1; last_addr = -1;
        pending = 0; done = 0; aborted = 0; lat_left = 0; req_addr = '0;
        bus.fetch_start = 1'b1;
        bus.fetch_row   = 6'(row);
        bus.swap        = swap_first;
        tick();
        cycles = 1;
        while (!done && !aborted && cycles < 4000) begin
            if (bus.fetch_done) begin
                done = 1;
                check("busy_at_done", 32'(bus.busy), 32'd0);
            end else begin
                check("busy_during", 32'(bus.busy), 32'd1);
                if (hold_known && !(swap_first && cycles == 1))
                    check("video_hold", bus.cell_out, hold_val);
                if (pending) begin
                    check("req_low_in_wait", 32'(bus.rd_request), 32'd0);
                    check("addr_stable", 32'(bus.rd_address), 32'(req_addr));
                    if (abort_at >= 0 && n_req == abort_at + 1) begin
                        aborted = 1;
                    end else if (lat_left == 0) begin
                        bus.rd_done = 1'b1;
                        bus.rd_data = 32'(req_addr);
                        pending     = 0;
                    end else begin
                        lat_left--;
                    end
                end else if (bus.rd_request) begin
                    check("rd_address", 32'(bus.rd_address), 32'(4 * (row * COLUMNS + n_req)));
                    req_addr = bus.rd_address;
                    if (first_addr < 0) first_addr = int'(bus.rd_address);
                    last_addr = int'(bus.rd_address);
                    n_req++;
                    pending  = 1;
                    lat_left = int'($urandom_range(1, max_lat)) - 1;
                end
                bus.swap = swap_mid && (cycles == 30);
                if (refetch && cycles == 40) begin
                    bus.fetch_start = 1'b1;
                    bus.fetch_row   = 6'((row + 7) % 64);
                end
                if (!aborted) begin
                    tick();
                    cycles++;
                end
            end
        end
        if (!done && !aborted) begin
            checks++;
            failures++;
            $display("FAIL fetch_timeout row=%0d actual=no_fetch_done required=fetch_done", row);
        end
        total_cycles = cycles + 1;
        if (done) begin
            for (int c = 0; c < COLUMNS; c++) model_bank[back][c] = ref_cell(row, c);
            bank_known[back] = 1;
            if (swap_mid) model_front = 1 - model_front;
            tick();
            check("done_pulse", 32'(bus.fetch_done), 32'd0);
            check("req_after", 32'(bus.rd_request), 32'd0);
            check("busy_after", 32'(bus.busy), 32'd0);
            if (bank_known[model_front])
                check("video_after", bus.cell_out, model_bank[model_front][vcol]);
        end else if (aborted) begin
            for (int c = 0; c < abort_at; c++) model_bank[back][c] = ref_cell(row, c);
        end
        $display("fetch row=%0d reqs=%0d first=%0d last=%0d cycles=%0d aborted=%0d",
                 row, n_req, first_addr, last_addr, total_cycles, aborted);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_req, first_addr, last_addr, cyc, row;
        bit sm, rf, sf;

        vecs[0] = '{row: 0,  max_lat: 1, swap_mid: 0, refetch: 0, exp_first: 0,     exp_last: 316,   exp_reqs: 80, exp_cycles: 162};
        vecs[1] = '{row: 50, max_lat: 1, swap_mid: 1, refetch: 0, exp_first: 16000, exp_last: 16316, exp_reqs: 80, exp_cycles: 162};
        vecs[2] = '{row: 51, max_lat: 1, swap_mid: 0, refetch: 0, exp_first: -1,    exp_last: -1,    exp_reqs: 0,  exp_cycles: 82};
        vecs[3] = '{row: 63, max_lat: 1, swap_mid: 1, refetch: 0, exp_first: -1,    exp_last: -1,    exp_reqs: 0,  exp_cycles: 82};
        vecs[4] = '{row: 25, max_lat: 1, swap_mid: 1, refetch: 1, exp_first: 8000,  exp_last: 8316,  exp_reqs: 80, exp_cycles: 162};

        bus.fetch_start = 1'b0;
        bus.fetch_row   = '0;
        bus.swap        = 1'b0;
        bus.rd_data     = '0;
        bus.rd_done     = 1'b0;
        bus.cell_column = '0;
        model_front     = 0;
        bank_known[0]   = 0;
        bank_known[1]   = 0;

        reset = 1'b1;
        repeat (3) tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.fetch_done), 32'd0);
        check("rst_req", 32'(bus.rd_request), 32'd0);
        check("rst_addr", 32'(bus.rd_address), 32'd0);
        check("rst_cell", bus.cell_out, 32'd0);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            run_fetch(vecs[i].row, vecs[i].max_lat, vecs[i].swap_mid, vecs[i].refetch, 1'b0, -1,
                      n_req, first_addr, last_addr, cyc);
            check("vec_reqs", 32'(n_req), 32'(vecs[i].exp_reqs));
            check("vec_first", 32'(first_addr), 32'(vecs[i].exp_first));
            check("vec_last", 32'(last_addr), 32'(vecs[i].exp_last));
            check("vec_cycles", 32'(cyc), 32'(vecs[i].exp_cycles));
            if (!vecs[i].swap_mid) do_swap();
            verify_front($sformatf("vec%0d", i));
        end

        for (int it = 0; it < 6; it++) begin
            row = int'($urandom_range(0, 63));
            sm  = 1'($urandom_range(0, 1));
            rf  = 1'($urandom_range(0, 1));
            sf  = 1'($urandom_range(0, 1));
            bus.rd_done = 1'b1;
            bus.rd_data = 32'hDEADBEEF;
            tick();
            run_fetch(row, 7, sm, rf, sf, -1, n_req, first_addr, last_addr, cyc);
            check("rnd_reqs", 32'(n_req), (row < ROWS) ? 32'(COLUMNS) : 32'd0);
            check("rnd_first", 32'(first_addr), (row < ROWS) ? 32'(4 * row * COLUMNS) : 32'hFFFFFFFF);
            if (!sm) do_swap();
            verify_front($sformatf("rnd%0d", it));
        end

        // Abort a fetch in the middle of column 40, then confirm a late rd_done lands nowhere.
        if (model_front == 1) do_swap();
        run_fetch(2, 3, 1'b0, 1'b0, 1'b0, 40, n_req, first_addr, last_addr, cyc);
        check("abort_reqs", 32'(n_req), 32'd41);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_front = 0;
        check("abort_req_low", 32'(bus.rd_request), 32'd0);
        check("abort_busy_low", 32'(bus.busy), 32'd0);
        check("abort_no_done", 32'(bus.fetch_done), 32'd0);
        bus.rd_done = 1'b1;
        bus.rd_data = 32'hDEADBEEF;
        tick();
        check("late_done_idle", 32'(bus.busy), 32'd0);
        do_swap();
        verify_front("after_reset");
        run_fetch(1, 2, 1'b0, 1'b0, 1'b0, -1, n_req, first_addr, last_addr, cyc);
        check("row1_first", 32'(first_addr), 32'd320);
        check("row1_reqs", 32'(n_req), 32'd80);
        do_swap();
        verify_front("row1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
